// File: rtl/arya_sched_pkg.sv
// Shared types and default sizing for the Arya thread scheduler.
//   sched_state_e : scheduler sequencing states
//   ARYA_*        : default parameter values for the 4-thread core
package arya_sched_pkg;

    localparam int unsigned ARYA_NUM_THREADS     = 4;
    localparam int unsigned ARYA_THREAD_BITS     = 2;
    localparam int unsigned ARYA_INST_ADDR_WIDTH = 9;
    localparam int unsigned ARYA_PC_STRIDE       = 128;
    localparam int unsigned ARYA_DRAIN_CYCLES    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   i_req       : request mask, one bit per requester
//   i_last      : index granted most recently
//   o_sel       : first requester after i_last, scanning cyclically
//   o_any_valid : at least one request present
module rr_pick #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned IDX_BITS = 2
) (
    input  logic [NUM_REQ-1:0]  i_req,
    input  logic [IDX_BITS-1:0] i_last,
    output logic [IDX_BITS-1:0] o_sel,
    output logic                o_any_valid
);

    always_comb begin
        int w_idx;
        o_sel = '0;
        // Scan farthest-to-nearest so the nearest requester after i_last is written last.
        for (int off = int'(NUM_REQ); off >= 1; off--) begin
            w_idx = (int'(i_last) + off) % int'(NUM_REQ);
            if (i_req[IDX_BITS'(w_idx)]) begin
                o_sel = IDX_BITS'(w_idx);
            end
        end
        o_any_valid = |i_req;
    end

endmodule

// File: rtl/thread_scheduler.sv
// Fine-grained round-robin thread scheduler for the Arya core.
//   i_clk, i_reset_n          : clock, asynchronous active-low reset
//   i_start                   : (re)launch all threads from IDLE or DONE
//   i_stall                   : freeze issue
//   i_thread_done             : per-thread halt flags from the decoder
//   i_br_valid/thread_id/target : branch redirect from execute
//   o_fetch_valid/thread_id/pc  : registered fetch request
//   o_halted                  : sticky retired mask
//   o_busy, o_all_done        : RUN/DRAIN, DONE status
module thread_scheduler
    import arya_sched_pkg::*;
#(
    parameter int unsigned NUM_THREADS     = ARYA_NUM_THREADS,
    parameter int unsigned THREAD_BITS     = ARYA_THREAD_BITS,
    parameter int unsigned INST_ADDR_WIDTH = ARYA_INST_ADDR_WIDTH,
    parameter int unsigned PC_STRIDE       = ARYA_PC_STRIDE,
    parameter int unsigned DRAIN_CYCLES    = ARYA_DRAIN_CYCLES
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_start,
    input  logic                       i_stall,
    input  logic [NUM_THREADS-1:0]     i_thread_done,
    input  logic                       i_br_valid,
    input  logic [THREAD_BITS-1:0]     i_br_thread_id,
    input  logic [INST_ADDR_WIDTH-1:0] i_br_target,
    output logic                       o_fetch_valid,
    output logic [THREAD_BITS-1:0]     o_fetch_thread_id,
    output logic [INST_ADDR_WIDTH-1:0] o_fetch_pc,
    output logic [NUM_THREADS-1:0]     o_halted,
    output logic                       o_busy,
    output logic                       o_all_done
);

    localparam int unsigned CNT_W = $clog2(DRAIN_CYCLES) + 1;

    sched_state_e               r_state, w_state_next;
    logic [INST_ADDR_WIDTH-1:0] r_pc [NUM_THREADS];
    logic [THREAD_BITS-1:0]     r_last_tid;
    logic [CNT_W-1:0]           r_drain_cnt;
    logic [NUM_THREADS-1:0]     r_halted;
    logic                       r_fetch_valid;
    logic [THREAD_BITS-1:0]     r_fetch_tid;
    logic [INST_ADDR_WIDTH-1:0] r_fetch_pc;

    logic [NUM_THREADS-1:0]     w_runnable;
    logic [THREAD_BITS-1:0]     w_sel;
    logic                       w_any;
    logic                       w_issue;
    logic                       w_launch;
    logic [INST_ADDR_WIDTH-1:0] w_base;

    // A thread flagged done this cycle is already excluded from selection.
    assign w_runnable = ~(r_halted | i_thread_done);

    rr_pick #(
        .NUM_REQ  (NUM_THREADS),
        .IDX_BITS (THREAD_BITS)
    ) u_rr_pick (
        .i_req       (w_runnable),
        .i_last      (r_last_tid),
        .o_sel       (w_sel),
        .o_any_valid (w_any)
    );

    assign w_launch = ((r_state == IDLE) || (r_state == DONE)) && i_start;
    assign w_issue  = (r_state == RUN) && !i_stall && w_any;
    // Same-cycle redirect of the selected thread bypasses its stored PC.
    assign w_base   = (i_br_valid && (i_br_thread_id == w_sel)) ? i_br_target : r_pc[w_sel];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: if (i_start) w_state_next = RUN;
            RUN:        if (!w_any) w_state_next = DRAIN;
            DRAIN:      if (r_drain_cnt == CNT_W'(DRAIN_CYCLES - 1)) w_state_next = DONE;
            default:    w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < int'(NUM_THREADS); i++) begin
                r_pc[i] <= '0;
            end
            r_halted      <= '0;
            r_last_tid    <= THREAD_BITS'(NUM_THREADS - 1);
            r_drain_cnt   <= '0;
            r_fetch_valid <= 1'b0;
            r_fetch_tid   <= '0;
            r_fetch_pc    <= '0;
        end else begin
            r_fetch_valid <= w_issue;

            if (w_launch) begin
                for (int i = 0; i < int'(NUM_THREADS); i++) begin
                    r_pc[i] <= INST_ADDR_WIDTH'(i * PC_STRIDE);
                end
                r_halted   <= '0;
                r_last_tid <= THREAD_BITS'(NUM_THREADS - 1);
            end

            if (r_state == RUN) begin
                r_halted    <= r_halted | i_thread_done;
                r_drain_cnt <= '0;
                // Redirects land even while stalled; the issue write below wins for sel.
                if (i_br_valid && w_runnable[i_br_thread_id]) begin
                    r_pc[i_br_thread_id] <= i_br_target;
                end
                if (w_issue) begin
                    r_fetch_tid  <= w_sel;
                    r_fetch_pc   <= w_base;
                    r_pc[w_sel]  <= w_base + INST_ADDR_WIDTH'(1);
                    r_last_tid   <= w_sel;
                end
            end

            if (r_state == DRAIN) begin
                r_drain_cnt <= r_drain_cnt + CNT_W'(1);
            end
        end
    end

    assign o_fetch_valid     = r_fetch_valid;
    assign o_fetch_thread_id = r_fetch_tid;
    assign o_fetch_pc        = r_fetch_pc;
    assign o_halted          = r_halted;
    assign o_busy            = (r_state == RUN) || (r_state == DRAIN);
    assign o_all_done        = (r_state == DONE);

endmodule
